// File: rtl/stopwatch_time_bank_if.sv
// Bundles the slot-enable, display-select and time-bank result signals between the
// stopwatch controller (master) and the time bank (slave).
interface stopwatch_time_bank_if;
    logic [10:0] en;
    logic [3:0]  disp_sel;
    logic        disp_update;
    logic [23:0] disp_time;
    logic [10:0] ovf;
    logic        tick;

    modport master (
        output en,
        output disp_sel,
        output disp_update,
        input  disp_time,
        input  ovf,
        input  tick
    );

    modport slave (
        input  en,
        input  disp_sel,
        input  disp_update,
        output disp_time,
        output ovf,
        output tick
    );
endinterface

// File: rtl/stopwatch_time_bank.sv
// Eleven BCD mm:ss.cc time slots advanced by a free-running centisecond prescaler, plus a freezable display register.
// Optional build macro STOPWATCH_SATURATE_EN: a full slot holds at 59:59.99 instead of wrapping to 00:00.00.
module stopwatch_time_bank #(
    parameter int DIV = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_time_bank_if.slave bus
);
    localparam int               PRE_W    = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]  pre;
    logic              tick_q;
    logic [10:0][23:0] slot_q;
    logic [10:0][23:0] slot_next;
    logic [10:0]       ovf_q;
    logic [10:0]       ovf_next;
    logic [23:0]       disp_q;
    logic [23:0]       disp_mux;
    logic [24:0]       inc;

    // Returns {carry_out, incremented time}; digit limits are 9 except s1 and m1 which roll at 5.
    function automatic logic [24:0] bcd_inc(input logic [23:0] t);
        logic [23:0] n;
        logic        carry;
        logic [3:0]  lim;
        n     = t;
        carry = 1'b1;
        lim   = 4'd9;
        for (int k = 0; k < 6; k++) begin
            lim = (k == 3 || k == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (n[k*4 +: 4] == lim) begin
                    n[k*4 +: 4] = 4'd0;
                end else begin
                    n[k*4 +: 4] = n[k*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return {carry, n};
    endfunction

    always_comb begin
        slot_next = slot_q;
        ovf_next  = ovf_q;
        inc       = '0;
        for (int i = 0; i < 11; i++) begin
            inc = bcd_inc(slot_q[i]);
            if (tick_q && bus.en[i]) begin
                ovf_next[i] = ovf_q[i] | inc[24];
`ifdef STOPWATCH_SATURATE_EN
                slot_next[i] = inc[24] ? slot_q[i] : inc[23:0];
`else
                slot_next[i] = inc[23:0];
`endif
            end
        end
    end

    // Display reads the slot before this cycle's increment; out-of-range selects show zero.
    always_comb begin
        disp_mux = '0;
        for (int i = 0; i < 11; i++) begin
            if (bus.disp_sel == 4'(i)) begin
                disp_mux = slot_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre    <= '0;
            tick_q <= 1'b0;
            slot_q <= '0;
            ovf_q  <= '0;
            disp_q <= '0;
        end else begin
            if (pre == PRE_LAST) begin
                pre    <= '0;
                tick_q <= 1'b1;
            end else begin
                pre    <= pre + PRE_W'(1);
                tick_q <= 1'b0;
            end
            slot_q <= slot_next;
            ovf_q  <= ovf_next;
            if (bus.disp_update) begin
                disp_q <= disp_mux;
            end
        end
    end

    assign bus.disp_time = disp_q;
    assign bus.ovf       = ovf_q;
    assign bus.tick      = tick_q;
endmodule

// File: tb/tb_stopwatch_time_bank.sv
// Directed bench for stopwatch_time_bank with DIV=4: select tables plus hand-written
// sequences for prescaler timing, display freeze, overflow and reset priority.
module tb_stopwatch_time_bank;
    localparam int DIV = 4;

`ifdef STOPWATCH_SATURATE_EN
    localparam logic [23:0] OVF_FIRST  = 24'h595999;
    localparam logic [23:0] OVF_SECOND = 24'h595999;
`else
    localparam logic [23:0] OVF_FIRST  = 24'h000000;
    localparam logic [23:0] OVF_SECOND = 24'h000001;
`endif

    typedef struct {
        logic [3:0]  sel;
        logic [23:0] exp_time;
    } sel_vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stopwatch_time_bank_if bus();

    stopwatch_time_bank #(.DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] en_v, input logic [3:0] sel_v, input logic upd_v);
        bus.en          = en_v;
        bus.disp_sel    = sel_v;
        bus.disp_update = upd_v;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at the negedge where the n-th tick is seen; that tick is applied on the next posedge.
    task automatic waitTicks(input int n);
        int seen   = 0;
        int budget = (n + 4) * DIV;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.tick) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL tick_timeout: got %0d ticks expected %0d", seen, n);
        end
    endtask

    task automatic runTicks(input int n, input logic [10:0] en_v);
        if (bus.tick) @(negedge clk);
        bus.en = en_v;
        waitTicks(n);
        @(negedge clk);
        bus.en = '0;
    endtask

    task automatic runTable(input string name, input sel_vec_t vecs[$]);
        foreach (vecs[k]) begin
            bus.disp_sel = vecs[k].sel;
            @(negedge clk);
            checkOutput($sformatf("%s_sel%0d", name, vecs[k].sel), bus.disp_time, vecs[k].exp_time);
        end
    endtask

    initial begin
        sel_vec_t single_vecs[$];
        sel_vec_t split_vecs[$];
        int       budget;

        single_vecs.push_back('{4'd0, 24'h000100});
        for (int s = 1; s <= 10; s++) single_vecs.push_back('{4'(s), 24'h000000});
        for (int s = 0; s <= 15; s++) begin
            if (s >= 2 && s <= 10) split_vecs.push_back('{4'(s), 24'h020345});
            else                   split_vecs.push_back('{4'(s), 24'h000000});
        end

        // Reset state and prescaler cadence
        applyStimulus(11'h000, 4'd0, 1'b0);
        resetDut();
        checkOutput("reset_tick", {23'd0, bus.tick}, 24'd0);
        checkOutput("reset_disp", bus.disp_time, 24'h000000);
        checkOutput("reset_ovf", {13'd0, bus.ovf}, 24'd0);
        for (int c = 1; c <= 3 * DIV; c++) begin
            @(negedge clk);
            checkOutput($sformatf("tick_cycle%0d", c), {23'd0, bus.tick}, {23'd0, (c % DIV) == 0});
        end

        // Single slot counting
        resetDut();
        applyStimulus(11'h000, 4'd0, 1'b1);
        runTicks(100, 11'h001);
        checkOutput("single_latency", bus.disp_time, 24'h000099);
        @(negedge clk);
        checkOutput("single_disp", bus.disp_time, 24'h000100);
        runTable("single", single_vecs);

        // Split-style enables
        resetDut();
        applyStimulus(11'h000, 4'd0, 1'b1);
        runTicks(12345, 11'h7FC);
        runTable("split", split_vecs);
        checkOutput("split_ovf", {13'd0, bus.ovf}, 24'd0);

        // Display freeze
        resetDut();
        applyStimulus(11'h000, 4'd0, 1'b1);
        runTicks(37, 11'h001);
        checkOutput("freeze_latency", bus.disp_time, 24'h000036);
        @(negedge clk);
        checkOutput("freeze_pre", bus.disp_time, 24'h000037);
        bus.disp_update = 1'b0;
        runTicks(20, 11'h001);
        @(negedge clk);
        checkOutput("freeze_hold", bus.disp_time, 24'h000037);
        bus.disp_update = 1'b1;
        @(negedge clk);
        checkOutput("freeze_release", bus.disp_time, 24'h000057);

        // Overflow from a preloaded 59:59.99 in slot 10
        resetDut();
        applyStimulus(11'h000, 4'd10, 1'b1);
        if (bus.tick) @(negedge clk);
        force dut.slot_q = {24'h595999, 240'h0};
        @(negedge clk);
        release dut.slot_q;
        @(negedge clk);
        checkOutput("ovf_preload", bus.disp_time, 24'h595999);
        checkOutput("ovf_before", {13'd0, bus.ovf}, 24'd0);
        runTicks(1, 11'h400);
        checkOutput("ovf_set", {13'd0, bus.ovf}, {13'd0, 11'h400});
        @(negedge clk);
        checkOutput("ovf_slot_first", bus.disp_time, OVF_FIRST);
        runTicks(1, 11'h400);
        checkOutput("ovf_sticky", {13'd0, bus.ovf}, {13'd0, 11'h400});
        @(negedge clk);
        checkOutput("ovf_slot_second", bus.disp_time, OVF_SECOND);

        // Invalid select and reset priority over a tick
        resetDut();
        applyStimulus(11'h000, 4'd3, 1'b1);
        runTicks(5, 11'h7FF);
        @(negedge clk);
        checkOutput("all_en_slot3", bus.disp_time, 24'h000005);
        bus.disp_sel = 4'd12;
        @(negedge clk);
        checkOutput("invalid_sel", bus.disp_time, 24'h000000);
        bus.disp_sel = 4'd3;
        bus.en       = 11'h7FF;
        budget       = 2 * DIV;
        while (!bus.tick && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("tick_found", {23'd0, bus.tick}, 24'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstprio_tick", {23'd0, bus.tick}, 24'd0);
        checkOutput("rstprio_ovf", {13'd0, bus.ovf}, 24'd0);
        checkOutput("rstprio_disp", bus.disp_time, 24'h000000);
        for (int c = 1; c <= DIV; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rstprio_slot3_c%0d", c), bus.disp_time, 24'h000000);
            checkOutput($sformatf("rstprio_tick_c%0d", c), {23'd0, bus.tick}, {23'd0, c == DIV});
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstprio_recount", bus.disp_time, 24'h000001);
        bus.en = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
